// File: rtl/mux_seq_defs.sv
// Shared definitions for the mux_e break-before-make sequencer: state encodings,
// channel constants and default interval lengths.
package mux_seq_defs;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEL  = 3'd1,
      ON   = 3'd2,
      OFF  = 3'd3,
      DONE = 3'd4
   } state_e;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   localparam int GUARD_DEF  = 1;
   localparam int DWELL_DEF  = 4;
   localparam int SETTLE_DEF = 2;

   // Bits needed to hold the longest interval, max(GUARD, DWELL).
   function automatic int cnt_width(input int guard, input int dwell);
      int m;
      m = (guard > dwell) ? guard : dwell;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/mux_seq_timer.sv
// Loadable down-counter timing the SEL/ON/OFF intervals; holds at zero until reloaded.
module mux_seq_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] value_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign value_o = cnt_q;
   assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/mux_e_sequencer.sv
// Break-before-make scan controller for the enabled 2:1 mux: samples channel a then b.
// Define MUX_SEQ_CHECK_EN to add the sticky err output (y high while e has been low).
//
// state | meaning
// IDLE  | waiting for start, s=0 e=0
// SEL   | e low for GUARD cycles around the s change
// ON    | e high for DWELL cycles, y captured at cycle SETTLE
// OFF   | e low for GUARD cycles before next channel / finish
// DONE  | one cycle, valid pulse with new data_out
module mux_e_sequencer
   import mux_seq_defs::*;
#(
   parameter int GUARD  = GUARD_DEF,
   parameter int DWELL  = DWELL_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y,
   output logic       s,
   output logic       e,
   output logic [1:0] data_out,
   output logic       valid,
   output logic       busy
`ifdef MUX_SEQ_CHECK_EN
 , output logic       err
`endif
);

   localparam int CW = cnt_width(GUARD, DWELL);

   state_e     state_q, state_d;
   logic       ch_q, ch_d;
   logic       s_q, s_d, e_q, e_d;
   logic       busy_q, busy_d, valid_q, valid_d;
   logic [1:0] data_q, data_d, shadow_q, shadow_d;

   logic          tmr_load;
   logic [CW-1:0] tmr_val, tmr_value;
   logic          tmr_zero;

   mux_seq_timer #(.W(CW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .value_o    (tmr_value),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      s_d      = s_q;
      e_d      = e_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      data_d   = data_q;
      shadow_d = shadow_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         IDLE: if (start) begin
            state_d  = SEL;
            ch_d     = CH_A;
            s_d      = 1'b0;
            e_d      = 1'b0;
            busy_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = CW'(GUARD - 1);
         end
         SEL: if (tmr_zero) begin
            state_d  = ON;
            e_d      = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = CW'(DWELL - 1);
         end
         ON: begin
            // Timer counts DWELL-1 down to 0, so this value marks the end of cycle SETTLE.
            if (tmr_value == CW'(DWELL - SETTLE))
               shadow_d[ch_q] = y;
            if (tmr_zero) begin
               state_d  = OFF;
               e_d      = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = CW'(GUARD - 1);
            end
         end
         OFF: if (tmr_zero) begin
            if (ch_q == CH_A) begin
               state_d  = SEL;
               ch_d     = CH_B;
               s_d      = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = CW'(GUARD - 1);
            end else begin
               state_d = DONE;
               s_d     = 1'b0;
               valid_d = 1'b1;
               data_d  = shadow_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            s_d     = 1'b0;
            e_d     = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ch_q     <= CH_A;
         s_q      <= 1'b0;
         e_q      <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= 2'b00;
         shadow_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         s_q      <= s_d;
         e_q      <= e_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         shadow_q <= shadow_d;
      end
   end

   assign s        = s_q;
   assign e        = e_q;
   assign busy     = busy_q;
   assign valid    = valid_q;
   assign data_out = data_q;

`ifdef MUX_SEQ_CHECK_EN
   logic err_q;

   // e_q low at this edge means e was low for the whole cycle just ended.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else if (y && !e_q)
         err_q <= 1'b1;
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_mux_e_sequencer.sv
// Scoreboard bench for mux_e_sequencer: default build plus a GUARD=2/DWELL=5/SETTLE=4 instance.
module tb_mux_e_sequencer;

   typedef struct {
      logic [1:0] data;
      int         start_edge;
      int         lat;
   } exp_t;

   logic clk, rst;
   logic start0, a0, b0, yf0, y0, s0, e0, valid0, busy0;
   logic start1, a1, b1, y1, s1, e1, valid1, busy1;
   logic [1:0] data0, data1;
`ifdef MUX_SEQ_CHECK_EN
   logic err0, err1;
`endif

   int   cyc = 0;
   int   n_tests = 0, n_fail = 0;
   int   v0 = 0;
   exp_t q0[$], q1[$];
   exp_t x0, x1;
   int   run0 = 0, run1 = 0;
   logic s0_p = 1'b0, e0_p = 1'b0, s1_p = 1'b0, e1_p = 1'b0;

   // downstream mux_e behaviour: y = e & (s ? b : a); yf0 injects a stray high
   assign y0 = yf0 | (e0 & (s0 ? b0 : a0));
   assign y1 = e1 & (s1 ? b1 : a1);

   mux_e_sequencer dut0 (
      .clk(clk), .rst(rst), .start(start0), .y(y0), .s(s0), .e(e0),
      .data_out(data0), .valid(valid0), .busy(busy0)
`ifdef MUX_SEQ_CHECK_EN
    , .err(err0)
`endif
   );

   mux_e_sequencer #(.GUARD(2), .DWELL(5), .SETTLE(4)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .y(y1), .s(s1), .e(e1),
      .data_out(data1), .valid(valid1), .busy(busy1)
`ifdef MUX_SEQ_CHECK_EN
    , .err(err1)
`endif
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // scoreboard + break-before-make / enable-width monitors
   always @(negedge clk) begin
      if (rst) begin
         run0 = 0; s0_p = s0; e0_p = e0;
      end else begin
         if (valid0) begin
            v0++;
            if (q0.size() == 0) check("unexpected_valid0", 1, 0);
            else begin
               x0 = q0.pop_front();
               check("data0", int'(data0), int'(x0.data));
               check("latency0", cyc - x0.start_edge, x0.lat);
            end
         end
         if (s0 != s0_p) check("bbm0_e_low_at_s_change", int'(e0 | e0_p), 0);
         if (e0) run0++;
         else if (e0_p) begin check("e_width0", run0, 4); run0 = 0; end
         s0_p = s0; e0_p = e0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         run1 = 0; s1_p = s1; e1_p = e1;
      end else begin
         if (valid1) begin
            if (q1.size() == 0) check("unexpected_valid1", 1, 0);
            else begin
               x1 = q1.pop_front();
               check("data1", int'(data1), int'(x1.data));
               check("latency1", cyc - x1.start_edge, x1.lat);
            end
         end
         if (s1 != s1_p) check("bbm1_e_low_at_s_change", int'(e1 | e1_p), 0);
         if (e1) run1++;
         else if (e1_p) begin check("e_width1", run1, 5); run1 = 0; end
         s1_p = s1; e1_p = e1;
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", q0.size() + q1.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse0(input logic [1:0] d, output int e_edge);
      exp_t x;
      e_edge = cyc + 1;
      x.data = d; x.start_edge = e_edge; x.lat = 12;
      q0.push_back(x);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic pulse1(input logic [1:0] d, output int e_edge);
      exp_t x;
      e_edge = cyc + 1;
      x.data = d; x.start_edge = e_edge; x.lat = 18;
      q1.push_back(x);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
   endtask

   initial begin
      #(40 * 4000);
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int   ed;
      int   vbase;
      exp_t x;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
      a0 = 1'b0; b0 = 1'b0; yf0 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_s0", int'(s0), 0);
      check("rst_e0", int'(e0), 0);
      check("rst_data0", int'(data0), 0);
      check("rst_valid0", int'(valid0), 0);
      check("rst_busy0", int'(busy0), 0);
      check("rst_busy1", int'(busy1), 0);
`ifdef MUX_SEQ_CHECK_EN
      check("rst_err0", int'(err0), 0);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single scan, a=1 b=0
      a0 = 1'b1; b0 = 1'b0;
      pulse0(2'b01, ed);
      check("busy_after_start", int'(busy0), 1);
      drain(60);

      // start held high: back-to-back scans, one IDLE cycle between
      a0 = 1'b0; b0 = 1'b1;
      ed = cyc + 1;
      x.data = 2'b10; x.start_edge = ed;      x.lat = 12; q0.push_back(x);
      x.data = 2'b11; x.start_edge = ed + 14; x.lat = 12; q0.push_back(x);
      start0 = 1'b1;
      wait_cyc(ed + 12);
      check("held_busy_done", int'(busy0), 1);
      wait_cyc(ed + 13);
      check("held_busy_gap", int'(busy0), 0);
      a0 = 1'b1;
      wait_cyc(ed + 14);
      check("held_busy_restart", int'(busy0), 1);
      wait_cyc(ed + 20);
      start0 = 1'b0;
      drain(60);

      // start pulses during SEL, ON and OFF are ignored
      vbase = v0;
      a0 = 1'b0; b0 = 1'b0;
      pulse0(2'b00, ed);
      start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      wait_cyc(ed + 3); start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      wait_cyc(ed + 5); start0 = 1'b1; @(negedge clk); start0 = 1'b0;
      drain(60);
      repeat (16) @(negedge clk);
      check("one_valid_per_start", v0 - vbase, 1);
      check("idle_after_ignored", int'(busy0), 0);

      // stray y high during the first OFF cycle
      a0 = 1'b1; b0 = 1'b0;
      pulse0(2'b01, ed);
      wait_cyc(ed + 5);
`ifdef MUX_SEQ_CHECK_EN
      check("err_before", int'(err0), 0);
`endif
      yf0 = 1'b1;
      wait_cyc(ed + 6);
      yf0 = 1'b0;
`ifdef MUX_SEQ_CHECK_EN
      check("err_set", int'(err0), 1);
`endif
      drain(60);
`ifdef MUX_SEQ_CHECK_EN
      check("err_sticky", int'(err0), 1);
`endif

      // asynchronous reset during channel-b ON
      a0 = 1'b1; b0 = 1'b1;
      pulse0(2'b11, ed);
      wait_cyc(ed + 9);
      check("pre_rst_s", int'(s0), 1);
      check("pre_rst_e", int'(e0), 1);
      #7 rst = 1'b1;
      #1;
      check("rst_mid_s", int'(s0), 0);
      check("rst_mid_e", int'(e0), 0);
      check("rst_mid_busy", int'(busy0), 0);
      check("rst_mid_valid", int'(valid0), 0);
      check("rst_mid_data", int'(data0), 0);
`ifdef MUX_SEQ_CHECK_EN
      check("rst_mid_err", int'(err0), 0);
`endif
      q0.delete();
      @(negedge clk);
      #5 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("aborted_no_valid", int'(valid0), 0);
      pulse0(2'b11, ed);
      drain(60);

      // GUARD=2 DWELL=5 SETTLE=4: plain scan, then narrow windows at the sample points
      a1 = 1'b1; b1 = 1'b1;
      pulse1(2'b11, ed);
      drain(80);
      a1 = 1'b0; b1 = 1'b0;
      pulse1(2'b11, ed);
      wait_cyc(ed + 5);  a1 = 1'b1;
      wait_cyc(ed + 6);  a1 = 1'b0;
      wait_cyc(ed + 14); b1 = 1'b1;
      wait_cyc(ed + 15); b1 = 1'b0;
      drain(80);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
